mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Multi-cycle sequencer for data-memory loads/stores issued by the decoder.
//  Latches one request, drives a req/ack handshake to data memory, stalls the PC,
//  then returns read data to the register file.
//  Sits between decoder, register file (loadEn/storEn/loadData/reg_dst) and data memory.
// PARAMETERS
//  ADDR_W   8   data-memory address width
//  DATA_W   8   data width
//  TIMEOUT  15  max REQ cycles waiting for mem_ack before abort (1..255)
// PORTS
//  clk          in   1       single clock; all state updates on posedge
//  reset        in   1       asynchronous, active-high; forces IDLE, all outputs 0
//  mem_op_valid in   1       decoder presents a load/store; held while stall=1
//  mem_is_store in   1       1=store, 0=load; sampled with mem_op_valid
//  op_addr      in   ADDR_W  memory address for the op
//  op_reg       in   4       register code (src for store, dst for load)
//  stor_data    in   DATA_W  store data from register file
//  mem_req      out  1       memory request, held until ack or timeout
//  mem_we       out  1       write enable, valid with mem_req
//  mem_addr     out  ADDR_W  latched address
//  mem_wdata    out  DATA_W  latched store data
//  mem_ack      in   1       memory completion; rdata valid same cycle
//  mem_rdata    in   DATA_W  read data
//  load_en      out  1       one-cycle write strobe to register file
//  load_dst     out  4       latched op_reg, valid with load_en
//  load_data    out  DATA_W  captured mem_rdata, valid with load_en
//  stall        out  1       hold PC / decoder
//  op_done      out  1       one-cycle completion pulse
//  timeout_err  out  1       sticky abort flag
// BEHAVIOUR
//  States: IDLE, REQ, WB, DONE. Reset: IDLE; all outputs and latches 0.
//  IDLE: mem_op_valid=1 -> latch addr/reg/store flag/stor_data, clear timeout_err,
//   clear wait counter, go REQ. stall = mem_op_valid (combinational) in IDLE.
//  REQ: mem_req=1, mem_we=latched store flag, stall=1. Counter +1 per cycle.
//   mem_ack=1: load -> capture mem_rdata, go WB; store -> go DONE.
//   No ack and counter==TIMEOUT-1 -> set timeout_err, drop mem_req, go DONE (no WB).
//   ack in same cycle as timeout limit: ack wins, no error.
//  WB: load_en=1 for exactly one cycle, stall=1, go DONE.
//  DONE: op_done=1, stall=0 (PC advances this edge); mem_op_valid ignored; go IDLE.
//  Latency (ack in first REQ cycle): load 4 cycles valid->op_done; store 3.
//  mem_ack outside REQ ignored. mem_req never asserted outside REQ.
//  timeout_err stays set until reset or next accepted op.
//  Counter is 8-bit, saturates; never wraps.
//  Latched fields stable from REQ entry through DONE; input changes ignored.
//  Reset mid-op: mem_req, load_en, stall drop asynchronously; no partial writeback.
//  Back-to-back ops: new op accepted earliest in IDLE cycle after DONE.
// TESTING
//  load addr 0x20, ack after 2 cycles rdata 0xA5 -> mem_req 3 cyc, load_en 1 cyc, load_data 0xA5, dst=op_reg
//  store addr 0x7F data 0x3C, ack 1st cycle -> mem_we=1, mem_wdata 0x3C, no load_en, op_done 3 cyc after valid
//  load, no ack -> mem_req exactly 15 cyc, timeout_err=1, no load_en, op_done next; next op clears err
//  ack on 15th REQ cycle -> normal completion, timeout_err=0
//  reset asserted during REQ -> mem_req/stall 0 immediately, state IDLE, no load_en after release
//  stray mem_ack in IDLE/DONE, valid held through DONE -> no req, single op_done, no re-trigger

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: decoder, register-file and data-memory signals of the load/store sequencer
interface mem_access_ctrl_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              mem_op_valid;
  logic              mem_is_store;
  logic [ADDR_W-1:0] op_addr;
  logic [3:0]        op_reg;
  logic [DATA_W-1:0] stor_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              load_en;
  logic [3:0]        load_dst;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              op_done;
  logic              timeout_err;
  modport slave (
    input  mem_op_valid, mem_is_store, op_addr, op_reg, stor_data, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, load_en, load_dst, load_data, stall, op_done, timeout_err
  );
  modport master (
    output mem_op_valid, mem_is_store, op_addr, op_reg, stor_data, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, load_en, load_dst, load_data, stall, op_done, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: latches one load/store, runs the req/ack handshake with a timeout, stalls the PC and writes loads back
module mem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [3:0]        r_reg;
  logic              r_store, r_err;
  logic [7:0]        r_cnt;
  logic              w_accept, w_limit;
  assign w_accept = (r_state == IDLE) && bus.mem_op_valid;
  assign w_limit  = r_cnt == 8'(TIMEOUT - 1);
  always_comb begin
    w_next          = r_state;
    bus.mem_req     = r_state == REQ;
    bus.mem_we      = (r_state == REQ) && r_store;
    bus.load_en     = r_state == WB;
    bus.op_done     = r_state == DONE;
    bus.stall       = (r_state == IDLE) ? bus.mem_op_valid : r_state != DONE;
    bus.mem_addr    = r_addr;
    bus.mem_wdata   = r_wdata;
    bus.load_dst    = r_reg;
    bus.load_data   = r_rdata;
    bus.timeout_err = r_err;
    case (r_state)
      IDLE:    w_next = bus.mem_op_valid ? REQ : IDLE;
      REQ:     w_next = bus.mem_ack ? (r_store ? DONE : WB) : (w_limit ? DONE : REQ);
      WB:      w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_reg   <= '0;
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= bus.op_addr;
        r_wdata <= bus.stor_data;
        r_reg   <= bus.op_reg;
        r_store <= bus.mem_is_store;
        r_err   <= 1'b0;
        r_cnt   <= '0;
      end
      if (r_state == REQ) begin
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        if (bus.mem_ack && !r_store) r_rdata <= bus.mem_rdata;
        if (!bus.mem_ack && w_limit) r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized load/store traffic against a transaction-level timeline model of the sequencer
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus();
  mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [7:0] mem [256];
  bit chk = 0;
  bit exp_req, exp_we, exp_le, exp_stall, exp_done, exp_err;
  logic [7:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0] exp_dst;
  bit err_state = 0;
  int cur_c = 0, done_c = -1, n_req = 0, n_le = 0, n_done = 0;
  logic [7:0] last_ld, last_wd;
  logic [3:0] last_dst;

  task automatic ck(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk) begin
    ck("mem_req", 32'(bus.mem_req), 32'(exp_req));
    if (exp_req) begin
      ck("mem_we", 32'(bus.mem_we), 32'(exp_we));
      ck("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      if (exp_we) ck("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
    end
    ck("load_en", 32'(bus.load_en), 32'(exp_le));
    if (exp_le) begin
      ck("load_dst", 32'(bus.load_dst), 32'(exp_dst));
      ck("load_data", 32'(bus.load_data), 32'(exp_ld));
    end
    ck("stall", 32'(bus.stall), 32'(exp_stall));
    ck("op_done", 32'(bus.op_done), 32'(exp_done));
    ck("timeout_err", 32'(bus.timeout_err), 32'(exp_err));
    if (bus.mem_req) n_req++;
    if (bus.mem_req && bus.mem_we) last_wd = bus.mem_wdata;
    if (bus.load_en) begin
      n_le++;
      last_ld = bus.load_data;
      last_dst = bus.load_dst;
    end
    if (bus.op_done) begin
      n_done++;
      done_c = cur_c;
    end
  end

  task automatic clr();
    n_req = 0; n_le = 0; n_done = 0; done_c = -1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_op_valid = 0;
      bus.mem_is_store = 1'($urandom);
      bus.op_addr = 8'($urandom);
      bus.mem_ack = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      {exp_req, exp_le, exp_stall, exp_done} = '0;
      exp_err = err_state;
      chk = 1;
      @(posedge clk); #1;
    end
  endtask

  // ackd: REQ cycle (0-based) on which memory acks; >= TIMEOUT means it never does
  task automatic run_op(input bit st, input logic [7:0] a, input logic [3:0] r, input logic [7:0] d,
                        input int ackd, input bit stray);
    bit ok = ackd < TIMEOUT;
    int nreq = ok ? ackd + 1 : TIMEOUT;
    int last_c = nreq + ((ok && !st) ? 2 : 1);
    for (int c = 0; c <= last_c; c++) begin
      bit in_req = c >= 1 && c <= nreq;
      bit acking = in_req && ok && c == nreq;
      bus.mem_op_valid = 1;
      bus.mem_is_store = (c == 0) ? st : 1'($urandom);
      bus.op_addr = (c == 0) ? a : 8'($urandom);
      bus.op_reg = (c == 0) ? r : 4'($urandom);
      bus.stor_data = (c == 0) ? d : 8'($urandom);
      bus.mem_ack = in_req ? acking : (stray & 1'($urandom));
      bus.mem_rdata = (acking && !st) ? mem[a] : 8'($urandom);
      exp_req = in_req;
      exp_we = st;
      exp_addr = a;
      exp_wdata = d;
      exp_le = ok && !st && c == nreq + 1;
      exp_dst = r;
      exp_ld = mem[a];
      exp_stall = c != last_c;
      exp_done = c == last_c;
      exp_err = (c == 0) ? err_state : (c == last_c && !ok);
      cur_c = c;
      chk = 1;
      @(posedge clk); #1;
      if (acking && st) mem[a] = d;
    end
    err_state = !ok;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    bus.mem_op_valid = 0; bus.mem_is_store = 0; bus.op_addr = 0; bus.op_reg = 0;
    bus.stor_data = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    @(posedge clk); @(posedge clk); #1;
    ck("rst mem_req", 32'(bus.mem_req), 0);
    ck("rst stall", 32'(bus.stall), 0);
    ck("rst load_en", 32'(bus.load_en), 0);
    ck("rst op_done", 32'(bus.op_done), 0);
    ck("rst timeout_err", 32'(bus.timeout_err), 0);
    ck("rst mem_addr", 32'(bus.mem_addr), 0);
    reset = 0;
    idle(2);

    mem[8'h20] = 8'hA5;
    clr(); run_op(0, 8'h20, 4'h5, 8'h00, 2, 0);
    ck("load req cycles", n_req, 3);
    ck("load load_en cycles", n_le, 1);
    ck("load data", 32'(last_ld), 32'hA5);
    ck("load dst", 32'(last_dst), 32'h5);
    ck("load done cycle", done_c, 5);
    idle(1);

    clr(); run_op(1, 8'h7F, 4'h2, 8'h3C, 0, 0);
    ck("store req cycles", n_req, 1);
    ck("store wdata", 32'(last_wd), 32'h3C);
    ck("store no load_en", n_le, 0);
    ck("store done cycle", done_c, 2);
    idle(1);

    clr(); run_op(0, 8'h11, 4'h9, 8'h00, 99, 0);
    ck("timeout req cycles", n_req, TIMEOUT);
    ck("timeout no load_en", n_le, 0);
    ck("timeout done cycle", done_c, TIMEOUT + 1);
    ck("timeout sticky", 32'(bus.timeout_err), 1);
    idle(2);
    ck("timeout still sticky", 32'(bus.timeout_err), 1);

    clr(); run_op(0, 8'h12, 4'h3, 8'h00, 0, 0);
    ck("err cleared by next op", 32'(bus.timeout_err), 0);
    ck("load done cycle ack0", done_c, 3);

    clr(); run_op(0, 8'h13, 4'h4, 8'h00, TIMEOUT - 1, 0);
    ck("late ack req cycles", n_req, TIMEOUT);
    ck("late ack load_en", n_le, 1);
    ck("late ack no err", 32'(bus.timeout_err), 0);

    clr(); run_op(1, 8'h40, 4'h1, 8'h77, 1, 1);
    idle(1);
    ck("stray single op_done", n_done, 1);
    ck("stray req cycles", n_req, 2);

    chk = 0;
    bus.mem_op_valid = 1; bus.mem_is_store = 0; bus.op_addr = 8'h55; bus.op_reg = 4'h6; bus.mem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ck("pre-reset mem_req", 32'(bus.mem_req), 1);
    #2 bus.mem_op_valid = 0; reset = 1;
    #1;
    ck("async rst mem_req", 32'(bus.mem_req), 0);
    ck("async rst stall", 32'(bus.stall), 0);
    ck("async rst load_en", 32'(bus.load_en), 0);
    @(posedge clk); #1;
    reset = 0;
    err_state = 0;
    clr(); idle(4);
    ck("post-reset no load_en", n_le, 0);
    ck("post-reset no req", n_req, 0);

    for (int k = 0; k < 60; k++) begin
      run_op(1'($urandom), 8'($urandom), 4'($urandom), 8'($urandom),
             int'($urandom_range(0, TIMEOUT + 3)), 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    chk = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
